// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimator frame scheduler.
package me_pkg;

    // Scheduler states, one macroblock in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int CYCLES_PER_MB_DEF = 4112;
    localparam int SETTLE_DEF        = 2;
    localparam int DIST_W_DEF        = 8;
    localparam int CNT_W             = 13;   // wide enough for the 0..4111 search count
    localparam int VEC_W             = 4;    // signed vector component width
    localparam int POS_W             = 4;    // macroblock column/row width

    // res_data = {mb_row, mb_col, best_y, best_x, best_dist}; offsets are above best_dist
    localparam int RES_HDR_W   = 2 * POS_W + 2 * VEC_W;
    localparam int RES_X_OFS   = 0;
    localparam int RES_Y_OFS   = VEC_W;
    localparam int RES_COL_OFS = 2 * VEC_W;
    localparam int RES_ROW_OFS = 2 * VEC_W + POS_W;

endpackage

// File: rtl/me_frame_scheduler_if.sv
// Handshake/data bundle between the frame scheduler and its loader, estimator,
// comparator and host.
interface me_frame_scheduler_if
    import me_pkg::*;
#(
    parameter int DIST_W = DIST_W_DEF
) ();

    logic                        frame_start;
    logic                        frame_abort;
    logic                        load_req;
    logic                        load_ack;
    logic [POS_W-1:0]            mb_col;
    logic [POS_W-1:0]            mb_row;
    logic                        me_start;
    logic [DIST_W-1:0]           best_dist;
    logic [VEC_W-1:0]            best_x;
    logic [VEC_W-1:0]            best_y;
    logic                        res_valid;
    logic                        res_ready;
    logic [RES_HDR_W+DIST_W-1:0] res_data;
    logic                        busy;
    logic                        frame_done;
    logic                        aborted;

    // Scheduler side
    modport slave (
        input  frame_start, frame_abort, load_ack, best_dist, best_x, best_y, res_ready,
        output load_req, mb_col, mb_row, me_start, res_valid, res_data, busy, frame_done, aborted
    );

    // Host / environment side
    modport master (
        output frame_start, frame_abort, load_ack, best_dist, best_x, best_y, res_ready,
        input  load_req, mb_col, mb_row, me_start, res_valid, res_data, busy, frame_done, aborted
    );

endinterface

// File: rtl/me_cycle_timer.sv
// Interval timer shared by the RUN and DRAIN phases: clear, count while enabled,
// flag the terminal value.
module me_cycle_timer
    import me_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Interval counter: clear wins over enable so every phase starts at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = i_en && (r_count == i_last);

endmodule

// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer: walks the macroblock grid in raster order, runs one
// full search per macroblock and hands each packed result to the host.
module me_frame_scheduler
    import me_pkg::*;
#(
    parameter int MB_COLS       = 4,
    parameter int MB_ROWS       = 3,
    parameter int CYCLES_PER_MB = CYCLES_PER_MB_DEF,
    parameter int SETTLE        = SETTLE_DEF,
    parameter int DIST_W        = DIST_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    me_frame_scheduler_if.slave   bus
);

    localparam int RES_W = RES_HDR_W + DIST_W;
    localparam logic [POS_W-1:0] LAST_COL   = POS_W'(MB_COLS - 1);
    localparam logic [POS_W-1:0] LAST_ROW   = POS_W'(MB_ROWS - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(CYCLES_PER_MB - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(SETTLE - 1);

    state_t             r_state;
    state_t             w_state_seq;
    state_t             w_state_nxt;
    logic               w_abort;
    logic               w_handshake;
    logic               w_last_mb;
    logic               w_tc;
    logic               w_tmr_clear;
    logic               w_tmr_en;
    logic [CNT_W-1:0]   w_tmr_last;

    logic               r_load_req;
    logic               r_me_start;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_aborted;
    logic [POS_W-1:0]   r_mb_col;
    logic [POS_W-1:0]   r_mb_row;
    logic [RES_W-1:0]   r_res_data;

    assign w_abort     = bus.frame_abort && (r_state != ST_IDLE);
    assign w_handshake = r_res_valid && bus.res_ready;
    assign w_last_mb   = (r_mb_col == LAST_COL) && (r_mb_row == LAST_ROW);

    // Normal sequencing, ignoring abort.
    always_comb begin
        w_state_seq = r_state;
        case (r_state)
            ST_IDLE:  if (bus.frame_start) w_state_seq = ST_LOAD;  else w_state_seq = ST_IDLE;
            ST_LOAD:  if (bus.load_ack)    w_state_seq = ST_RUN;   else w_state_seq = ST_LOAD;
            ST_RUN:   if (w_tc)            w_state_seq = ST_DRAIN; else w_state_seq = ST_RUN;
            ST_DRAIN: if (w_tc)            w_state_seq = ST_EMIT;  else w_state_seq = ST_DRAIN;
            ST_EMIT: begin
                if (w_handshake) begin
                    if (w_last_mb) w_state_seq = ST_DONE; else w_state_seq = ST_LOAD;
                end else begin
                    w_state_seq = ST_EMIT;
                end
            end
            ST_DONE:  w_state_seq = ST_IDLE;
            default:  w_state_seq = ST_IDLE;
        endcase
    end

    // Abort overrides every other transition; timer restarts on each state change.
    always_comb begin
        w_state_nxt = w_state_seq;
        w_tmr_last  = DRAIN_LAST;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = w_state_seq;
        end
        if (r_state == ST_RUN) begin
            w_tmr_last = RUN_LAST;
        end else begin
            w_tmr_last = DRAIN_LAST;
        end
    end

    assign w_tmr_clear = (w_state_nxt != r_state);
    assign w_tmr_en    = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    me_cycle_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_tmr_clear),
        .i_en    (w_tmr_en),
        .i_last  (w_tmr_last),
        .o_tc    (w_tc)
    );

    // State and control outputs, registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_load_req   <= 1'b0;
            r_me_start   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
        end else if (w_abort) begin
            r_state      <= ST_IDLE;
            r_load_req   <= 1'b0;
            r_me_start   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_load_req   <= (w_state_nxt == ST_LOAD);
            r_me_start   <= (w_state_nxt == ST_RUN);
            r_res_valid  <= (w_state_nxt == ST_EMIT);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= (w_state_nxt == ST_DONE);
            r_aborted    <= 1'b0;
        end
    end

    // Raster position and result capture; position is held from LOAD through the handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mb_col   <= {POS_W{1'b0}};
            r_mb_row   <= {POS_W{1'b0}};
            r_res_data <= {RES_W{1'b0}};
        end else if (w_abort) begin
            r_mb_col   <= {POS_W{1'b0}};
            r_mb_row   <= {POS_W{1'b0}};
            r_res_data <= r_res_data;
        end else begin
            if ((r_state == ST_IDLE) && bus.frame_start) begin
                r_mb_col <= {POS_W{1'b0}};
                r_mb_row <= {POS_W{1'b0}};
            end else if ((r_state == ST_EMIT) && w_handshake && !w_last_mb) begin
                if (r_mb_col == LAST_COL) begin
                    r_mb_col <= {POS_W{1'b0}};
                    r_mb_row <= r_mb_row + POS_W'(1);
                end else begin
                    r_mb_col <= r_mb_col + POS_W'(1);
                    r_mb_row <= r_mb_row;
                end
            end else begin
                r_mb_col <= r_mb_col;
                r_mb_row <= r_mb_row;
            end
            if ((r_state == ST_DRAIN) && w_tc) begin
                r_res_data[DIST_W-1:0]                       <= bus.best_dist;
                r_res_data[DIST_W+RES_X_OFS   +: VEC_W]      <= bus.best_x;
                r_res_data[DIST_W+RES_Y_OFS   +: VEC_W]      <= bus.best_y;
                r_res_data[DIST_W+RES_COL_OFS +: POS_W]      <= r_mb_col;
                r_res_data[DIST_W+RES_ROW_OFS +: POS_W]      <= r_mb_row;
            end else begin
                r_res_data <= r_res_data;
            end
        end
    end

    assign bus.load_req   = r_load_req;
    assign bus.me_start   = r_me_start;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.aborted    = r_aborted;
    assign bus.mb_col     = r_mb_col;
    assign bus.mb_row     = r_mb_row;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Self-checking bench for me_frame_scheduler on a 2x2 macroblock grid.
module tb_me_frame_scheduler;

    localparam int COLS   = 2;
    localparam int ROWS   = 2;
    localparam int CPM    = 4112;
    localparam int SETTLE = 2;
    localparam int DW     = 8;
    localparam int RW     = 16 + DW;
    localparam int MB_LAT = 1 + CPM + SETTLE + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    me_frame_scheduler_if #(.DIST_W(DW)) bus ();

    me_frame_scheduler #(
        .MB_COLS(COLS), .MB_ROWS(ROWS), .CYCLES_PER_MB(CPM), .SETTLE(SETTLE), .DIST_W(DW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Observation log, sampled on the falling edge
    int          cyc     = 0;
    int          run_len = 0;
    int          run_q[$];
    logic [RW-1:0] res_q[$];
    int          hs_cyc_q[$];
    int          fd_cyc_q[$];

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (bus.me_start) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            run_q.push_back(run_len);
            run_len <= 0;
        end
        if (bus.res_valid && bus.res_ready) begin
            res_q.push_back(bus.res_data);
            hs_cyc_q.push_back(cyc);
        end
        if (bus.frame_done) fd_cyc_q.push_back(cyc);
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.load_req;
            1:       return bus.me_start;
            2:       return bus.res_valid;
            3:       return bus.frame_done;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [37:0] outs();
        return {bus.load_req, bus.me_start, bus.res_valid, bus.busy, bus.frame_done,
                bus.aborted, bus.mb_col, bus.mb_row, bus.res_data};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_for(input int which, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_%s: still 0 after %0d clocks, required 1", name, budget);
        end
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic abort_out();
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", outs());
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (outs() !== 38'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got %h, required 0", outs());
        end
    endtask

    task automatic test_frame();
        bit ok;
        logic [3:0] bx, by;
        logic [DW-1:0] bd;
        logic [RW-1:0] exp_q[$];
        run_q.delete(); res_q.delete(); hs_cyc_q.delete(); fd_cyc_q.delete();
        bus.load_ack  = 1'b1;
        bus.res_ready = 1'b1;
        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                wait_for(0, MB_LAT + 10, "load_req", ok);
                checks++;
                if ({bus.mb_row, bus.mb_col} !== {4'(r), 4'(c)}) begin
                    failures++;
                    $display("FAIL frame_position: got row=%0d col=%0d, required row=%0d col=%0d",
                             bus.mb_row, bus.mb_col, r, c);
                end
                bx = 4'($urandom_range(15));
                by = 4'($urandom_range(15));
                bd = DW'($urandom_range(255));
                bus.best_x = bx; bus.best_y = by; bus.best_dist = bd;
                exp_q.push_back({4'(r), 4'(c), by, bx, bd});
                tick();
            end
        end
        wait_for(3, 2 * MB_LAT, "frame_done", ok);
        tick(); tick();
        checks++;
        if (res_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL frame_result_count: got %0d, required %0d", res_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL frame_result[%0d]: got %h, required %h", i, res_q[i], exp_q[i]);
            end
        end
        checks++;
        if (run_q.size() != ROWS * COLS) begin
            failures++;
            $display("FAIL me_start_runs: got %0d runs, required %0d", run_q.size(), ROWS * COLS);
        end
        foreach (run_q[i]) begin
            checks++;
            if (run_q[i] != CPM) begin
                failures++;
                $display("FAIL me_start_len[%0d]: got %0d, required %0d", i, run_q[i], CPM);
            end
        end
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            checks++;
            if (hs_cyc_q[i] - hs_cyc_q[i-1] != MB_LAT) begin
                failures++;
                $display("FAIL mb_latency[%0d]: got %0d, required %0d", i,
                         hs_cyc_q[i] - hs_cyc_q[i-1], MB_LAT);
            end
        end
        checks++;
        if (fd_cyc_q.size() != 1 || hs_cyc_q.size() == 0 ||
            fd_cyc_q[0] != hs_cyc_q[hs_cyc_q.size()-1] + 1) begin
            failures++;
            $display("FAIL frame_done_timing: got %0d pulses, required 1 pulse one clock after last handshake",
                     fd_cyc_q.size());
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_frame: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_pack_backpressure();
        bit ok;
        logic [RW-1:0] exp;
        exp = {4'h0, 4'h0, 4'h7, 4'h8, 8'hA5};
        bus.load_ack  = 1'b1;
        bus.res_ready = 1'b0;
        bus.best_x = 4'h8; bus.best_y = 4'h7; bus.best_dist = 8'hA5;
        pulse_start();
        wait_for(2, MB_LAT + 10, "res_valid", ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.res_valid, bus.load_req, bus.res_data} !== {1'b1, 1'b0, exp}) begin
                failures++;
                $display("FAIL emit_hold[%0d]: got valid=%b load_req=%b data=%h, required valid=1 load_req=0 data=%h",
                         i, bus.res_valid, bus.load_req, bus.res_data, exp);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        checks++;
        if ({bus.res_valid, bus.load_req, bus.mb_row, bus.mb_col} !== {1'b0, 1'b1, 4'd0, 4'd1}) begin
            failures++;
            $display("FAIL after_handshake: got valid=%b load_req=%b row=%0d col=%0d, required 0 1 0 1",
                     bus.res_valid, bus.load_req, bus.mb_row, bus.mb_col);
        end
        abort_out();
    endtask

    task automatic test_abort();
        bit ok;
        int fd_before;
        bus.load_ack  = 1'b1;
        bus.res_ready = 1'b1;
        pulse_start();
        tick();
        wait_for(0, MB_LAT + 10, "load_req", ok);
        wait_for(1, 10, "me_start", ok);
        repeat (1000) tick();
        fd_before = fd_cyc_q.size();
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        checks++;
        if ({bus.me_start, bus.busy, bus.aborted, bus.load_req, bus.res_valid} !== 5'b00100) begin
            failures++;
            $display("FAIL abort_edge: got me_start=%b busy=%b aborted=%b load_req=%b res_valid=%b, required 0 0 1 0 0",
                     bus.me_start, bus.busy, bus.aborted, bus.load_req, bus.res_valid);
        end
        tick();
        checks++;
        if (bus.aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse_len: got %b, required 0", bus.aborted);
        end
        repeat (5) tick();
        checks++;
        if (fd_cyc_q.size() != fd_before || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d frame_done pulses busy=%b, required 0 pulses busy=0",
                     fd_cyc_q.size() - fd_before, bus.busy);
        end
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        checks++;
        if ({bus.aborted, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL abort_in_idle: got aborted=%b busy=%b, required 0 0", bus.aborted, bus.busy);
        end
        bus.load_ack = 1'b0;
        pulse_start();
        checks++;
        if ({bus.load_req, bus.mb_row, bus.mb_col} !== {1'b1, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL restart_position: got load_req=%b row=%0d col=%0d, required 1 0 0",
                     bus.load_req, bus.mb_row, bus.mb_col);
        end
        abort_out();
    endtask

    task automatic test_ignore_while_busy();
        bit ok;
        bus.load_ack  = 1'b1;
        bus.res_ready = 1'b1;
        pulse_start();
        run_q.delete(); res_q.delete();
        wait_for(1, 10, "me_start", ok);
        bus.load_ack = 1'b0;
        repeat (100) tick();
        bus.frame_start = 1'b1;
        bus.load_ack    = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.load_ack    = 1'b0;
        checks++;
        if ({bus.me_start, bus.load_req, bus.busy, bus.mb_row, bus.mb_col} !== {3'b101, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL ignore_pulses: got me_start=%b load_req=%b busy=%b row=%0d col=%0d, required 1 0 1 0 0",
                     bus.me_start, bus.load_req, bus.busy, bus.mb_row, bus.mb_col);
        end
        bus.load_ack = 1'b1;
        wait_for(2, MB_LAT, "res_valid", ok);
        tick();
        wait_for(0, 10, "load_req", ok);
        checks++;
        if (run_q.size() < 1 || run_q[0] != CPM || {bus.mb_row, bus.mb_col} !== {4'd0, 4'd1}) begin
            failures++;
            $display("FAIL ignore_run_len: got runs=%0d first=%0d row=%0d col=%0d, required first=%0d row=0 col=1",
                     run_q.size(), (run_q.size() > 0) ? run_q[0] : -1, bus.mb_row, bus.mb_col, CPM);
        end
        abort_out();
    endtask

    task automatic test_async_reset();
        bit ok;
        bus.load_ack = 1'b1;
        pulse_start();
        wait_for(1, 10, "me_start", ok);
        repeat (50) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 38'd0) begin
            failures++;
            $display("FAIL async_reset: got %h, required 0", outs());
        end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({bus.busy, bus.load_req, bus.me_start} !== 3'b000) begin
                failures++;
                $display("FAIL idle_after_release[%0d]: got busy=%b load_req=%b me_start=%b, required 0 0 0",
                         i, bus.busy, bus.load_req, bus.me_start);
            end
        end
        bus.load_ack = 1'b0;
        pulse_start();
        checks++;
        if ({bus.load_req, bus.mb_row, bus.mb_col} !== {1'b1, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL start_after_reset: got load_req=%b row=%0d col=%0d, required 1 0 0",
                     bus.load_req, bus.mb_row, bus.mb_col);
        end
        abort_out();
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.frame_abort = 1'b0;
        bus.load_ack    = 1'b0;
        bus.res_ready   = 1'b0;
        bus.best_x      = 4'h0;
        bus.best_y      = 4'h0;
        bus.best_dist   = 8'h00;
        test_reset();
        test_frame();
        test_pack_backpressure();
        test_abort();
        test_ignore_while_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
